// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if -- bundle of the requester-side and FPU-side signals of the
// two-lane FPU arbiter.
//   req_valid/req_ready  : per-lane request handshake
//   req_op_a/req_op_b    : per-lane operands, lane i at [32i+31:32i]
//   rsp_valid/rsp_data/rsp_status : per-lane response pulse, shared data/status
//   fpu_start/fpu_op_a/fpu_op_b   : launch of the shared FPU adder
//   fpu_done/fpu_result/fpu_status: completion from the shared FPU adder
// Modports:
//   master : requesters plus FPU model (drives requests and FPU completion)
//   slave  : the arbiter
interface fpu_arbiter_if;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][31:0]  req_op_a;
   logic [1:0][31:0]  req_op_b;
   logic [1:0]        rsp_valid;
   logic [31:0]       rsp_data;
   logic [3:0]        rsp_status;
   logic              fpu_start;
   logic [31:0]       fpu_op_a;
   logic [31:0]       fpu_op_b;
   logic              fpu_done;
   logic [31:0]       fpu_result;
   logic [3:0]        fpu_status;

   modport master (
      output req_valid, req_op_a, req_op_b, fpu_done, fpu_result, fpu_status,
      input  req_ready, rsp_valid, rsp_data, rsp_status, fpu_start, fpu_op_a, fpu_op_b
   );

   modport slave (
      input  req_valid, req_op_a, req_op_b, fpu_done, fpu_result, fpu_status,
      output req_ready, rsp_valid, rsp_data, rsp_status, fpu_start, fpu_op_a, fpu_op_b
   );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter -- shares one FPU adder between two requesters, one transaction
// in flight at a time. Simultaneous requests are resolved by a round-robin
// pointer; a stalled FPU is abandoned after TIMEOUT cycles in WAIT.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : fpu_arbiter_if.slave (request, response and FPU signals)
//   busy   : high whenever the FSM is not IDLE
module fpu_arbiter #(
   parameter int unsigned TIMEOUT = 64   // legal 2..255
) (
   input  logic           clock,
   input  logic           reset,
   fpu_arbiter_if.slave   bus,
   output logic           busy
);

   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);
   localparam logic [3:0] ST_TIMEOUT = 4'b1001;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

   state_t       state, state_nxt;
   logic         gnt_sel;      // lane picked this cycle in IDLE
   logic         gnt_q;        // lane owning the in-flight transaction
   logic         ptr_q;        // preferred lane when both request
   logic         hs;           // handshake this cycle
   logic [7:0]   cnt_q;
   logic [31:0]  op_a_q, op_b_q;
   logic [31:0]  data_q;
   logic [3:0]   status_q;
   logic [1:0]   req_ready_c;
   logic [1:0]   rsp_valid_c;
   logic         fpu_start_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      gnt_sel     = 1'b0;
      hs          = 1'b0;
      req_ready_c = 2'b00;
      rsp_valid_c = 2'b00;
      fpu_start_c = 1'b0;
      case (state)
         IDLE: begin
            case (bus.req_valid)
               2'b01:   gnt_sel = 1'b0;
               2'b10:   gnt_sel = 1'b1;
               2'b11:   gnt_sel = ptr_q;
               default: gnt_sel = 1'b0;
            endcase
            // No backpressure from the arbiter side: any request present
            // in IDLE is granted, so the handshake completes immediately.
            if (|bus.req_valid) begin
               req_ready_c[gnt_sel] = 1'b1;
               hs                   = 1'b1;
               state_nxt            = ISSUE;
            end
         end
         ISSUE: begin
            fpu_start_c = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (bus.fpu_done || cnt_q == CNT_LAST) state_nxt = RESPOND;
         end
         RESPOND: begin
            rsp_valid_c[gnt_q] = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt_q    <= 1'b0;
         ptr_q    <= 1'b0;
         cnt_q    <= 8'd0;
         op_a_q   <= 32'd0;
         op_b_q   <= 32'd0;
         data_q   <= 32'd0;
         status_q <= 4'd0;
      end else begin
         if (hs) begin
            gnt_q  <= gnt_sel;
            op_a_q <= bus.req_op_a[gnt_sel];
            op_b_q <= bus.req_op_b[gnt_sel];
         end
         case (state)
            ISSUE: cnt_q <= 8'd0;
            WAIT: begin
               // fpu_done takes precedence over an expiring timeout.
               if (bus.fpu_done) begin
                  data_q   <= bus.fpu_result;
                  status_q <= bus.fpu_status;
               end else if (cnt_q == CNT_LAST) begin
                  data_q   <= 32'd0;
                  status_q <= ST_TIMEOUT;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RESPOND: ptr_q <= ~gnt_q;
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_status = status_q;
   assign bus.fpu_start  = fpu_start_c;
   assign bus.fpu_op_a   = op_a_q;
   assign bus.fpu_op_b   = op_b_q;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter -- directed bench for fpu_arbiter (TIMEOUT = 8). The bench
// plays both requesters and the FPU adder; all expected values are literal.
module tb_fpu_arbiter;

   logic clock;
   logic reset;
   logic busy;
   int   checks;
   int   errors;

   fpu_arbiter_if bus ();

   fpu_arbiter #(.TIMEOUT(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req_ready"},  32'(bus.req_ready),  32'd0);
      chk({tag, ".rsp_valid"},  32'(bus.rsp_valid),  32'd0);
      chk({tag, ".rsp_data"},   bus.rsp_data,        32'd0);
      chk({tag, ".rsp_status"}, 32'(bus.rsp_status), 32'd0);
      chk({tag, ".fpu_start"},  32'(bus.fpu_start),  32'd0);
      chk({tag, ".fpu_op_a"},   bus.fpu_op_a,        32'd0);
      chk({tag, ".fpu_op_b"},   bus.fpu_op_b,        32'd0);
      chk({tag, ".busy"},       32'(busy),           32'd0);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset          = 1'b1;
      bus.req_valid  = 2'b00;
      bus.req_op_a   = '0;
      bus.req_op_b   = '0;
      bus.fpu_done   = 1'b0;
      bus.fpu_result = 32'd0;
      bus.fpu_status = 4'd0;

      // ---- reset values
      #2 reset = 1'b0;
      tick();
      tick();
      chk_reset_outputs("rst");
      reset = 1'b1;

      // ---- single request, k = 3
      bus.req_op_a  = {32'h11111111, 32'h3E000000};
      bus.req_op_b  = {32'h22222222, 32'h3E000000};
      bus.req_valid = 2'b01;
      #1;
      chk("single.ready_c0", 32'(bus.req_ready), 32'h1);
      chk("single.busy_c0",  32'(busy),          32'h0);
      tick();                                   // cycle 1: ISSUE
      bus.req_valid = 2'b00;
      #1;
      chk("single.start_c1", 32'(bus.fpu_start), 32'h1);
      chk("single.op_a_c1",  bus.fpu_op_a,       32'h3E000000);
      chk("single.op_b_c1",  bus.fpu_op_b,       32'h3E000000);
      chk("single.ready_c1", 32'(bus.req_ready), 32'h0);
      chk("single.busy_c1",  32'(busy),          32'h1);
      tick();                                   // cycle 2: WAIT
      chk("single.start_c2", 32'(bus.fpu_start), 32'h0);
      tick();                                   // cycle 3
      tick();                                   // cycle 4: done
      bus.fpu_done   = 1'b1;
      bus.fpu_result = 32'h40000000;
      bus.fpu_status = 4'b0001;
      chk("single.novalid_c4", 32'(bus.rsp_valid), 32'h0);
      tick();                                   // cycle 5: RESPOND
      bus.fpu_done = 1'b0;
      #1;
      chk("single.rsp_valid_c5",  32'(bus.rsp_valid),  32'h1);
      chk("single.rsp_data_c5",   bus.rsp_data,        32'h40000000);
      chk("single.rsp_status_c5", 32'(bus.rsp_status), 32'h1);
      chk("single.op_a_hold_c5",  bus.fpu_op_a,        32'h3E000000);
      tick();                                   // cycle 6: IDLE
      chk("single.rsp_valid_c6",  32'(bus.rsp_valid),  32'h0);
      chk("single.busy_c6",       32'(busy),           32'h0);
      chk("single.data_hold_c6",  bus.rsp_data,        32'h40000000);

      // ---- simultaneous requests after reset: 0, 1, 0
      reset = 1'b0;
      #1;
      chk("rr.reset_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      tick();
      bus.req_op_a  = {32'h1A1A1A1A, 32'h0A0A0A0A};
      bus.req_op_b  = {32'h1B1B1B1B, 32'h0B0B0B0B};
      bus.req_valid = 2'b11;
      for (int t = 0; t < 3; t++) begin
         logic [1:0]  eg;
         logic [31:0] ea, eb, er;
         eg = (t == 1) ? 2'b10 : 2'b01;
         ea = (t == 1) ? 32'h1A1A1A1A : 32'h0A0A0A0A;
         eb = (t == 1) ? 32'h1B1B1B1B : 32'h0B0B0B0B;
         er = 32'hC0DE0000 + 32'(t);
         #1;
         chk($sformatf("rr%0d.ready", t), 32'(bus.req_ready), 32'(eg));
         tick();                                // ISSUE
         chk($sformatf("rr%0d.start", t), 32'(bus.fpu_start), 32'h1);
         chk($sformatf("rr%0d.op_a", t),  bus.fpu_op_a,       ea);
         chk($sformatf("rr%0d.op_b", t),  bus.fpu_op_b,       eb);
         chk($sformatf("rr%0d.ready_issue", t), 32'(bus.req_ready), 32'h0);
         tick();                                // WAIT, done with k = 1
         bus.fpu_done   = 1'b1;
         bus.fpu_result = er;
         bus.fpu_status = 4'b1111;
         tick();                                // RESPOND
         bus.fpu_done = 1'b0;
         #1;
         chk($sformatf("rr%0d.rsp_valid", t),  32'(bus.rsp_valid),  32'(eg));
         chk($sformatf("rr%0d.rsp_data", t),   bus.rsp_data,        er);
         chk($sformatf("rr%0d.rsp_status", t), 32'(bus.rsp_status), 32'hF);
         chk($sformatf("rr%0d.ready_resp", t), 32'(bus.req_ready),  32'h0);
         tick();                                // IDLE
      end
      bus.req_valid = 2'b00;

      // ---- timeout on requester 1 (TIMEOUT = 8)
      bus.req_op_a  = {32'h55555555, 32'h0};
      bus.req_op_b  = {32'h66666666, 32'h0};
      bus.req_valid = 2'b10;
      #1;
      chk("to.ready", 32'(bus.req_ready), 32'h2);
      tick();                                   // ISSUE
      bus.req_valid = 2'b00;
      chk("to.op_a", bus.fpu_op_a, 32'h55555555);
      tick();                                   // WAIT cnt 0
      chk("to.wait0_valid", 32'(bus.rsp_valid), 32'h0);
      for (int i = 1; i < 8; i++) begin
         tick();                                // WAIT cnt i
         chk($sformatf("to.wait%0d_valid", i), 32'(bus.rsp_valid), 32'h0);
         chk($sformatf("to.wait%0d_busy", i),  32'(busy),           32'h1);
      end
      tick();                                   // RESPOND
      chk("to.rsp_valid",  32'(bus.rsp_valid),  32'h2);
      chk("to.rsp_data",   bus.rsp_data,        32'h0);
      chk("to.rsp_status", 32'(bus.rsp_status), 32'h9);
      chk("to.busy_resp",  32'(busy),           32'h1);
      tick();
      chk("to.busy_after",  32'(busy),           32'h0);
      chk("to.valid_after", 32'(bus.rsp_valid),  32'h0);
      chk("to.status_hold", 32'(bus.rsp_status), 32'h9);

      // ---- fpu_done coincides with last timeout cycle
      bus.req_op_a  = {32'h0, 32'h12340000};
      bus.req_op_b  = {32'h0, 32'h56780000};
      bus.req_valid = 2'b01;
      tick();                                   // ISSUE
      bus.req_valid = 2'b00;
      tick();                                   // WAIT cnt 0
      for (int i = 1; i < 8; i++) tick();       // WAIT cnt 7
      bus.fpu_done   = 1'b1;
      bus.fpu_result = 32'h7E000000;
      bus.fpu_status = 4'b0011;
      tick();                                   // RESPOND
      bus.fpu_done = 1'b0;
      #1;
      chk("col.rsp_valid",  32'(bus.rsp_valid),  32'h1);
      chk("col.rsp_data",   bus.rsp_data,        32'h7E000000);
      chk("col.rsp_status", 32'(bus.rsp_status), 32'h3);
      tick();

      // ---- spurious fpu_done in IDLE
      bus.fpu_done   = 1'b1;
      bus.fpu_result = 32'hDEADBEEF;
      bus.fpu_status = 4'b1111;
      tick();
      bus.fpu_done = 1'b0;
      #1;
      chk("spur.rsp_valid",  32'(bus.rsp_valid),  32'h0);
      chk("spur.busy",       32'(busy),           32'h0);
      chk("spur.rsp_data",   bus.rsp_data,        32'h7E000000);
      chk("spur.rsp_status", 32'(bus.rsp_status), 32'h3);
      tick();
      chk("spur.rsp_valid2", 32'(bus.rsp_valid),  32'h0);

      // ---- reset during WAIT, late fpu_done afterwards
      bus.req_op_a  = {32'h77777777, 32'h0};
      bus.req_op_b  = {32'h88888888, 32'h0};
      bus.req_valid = 2'b10;
      tick();                                   // ISSUE
      bus.req_valid = 2'b00;
      tick();                                   // WAIT cnt 0
      tick();                                   // WAIT cnt 1
      chk("mid.busy_wait", 32'(busy), 32'h1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("mid.rst");
      tick();
      reset = 1'b1;
      tick();
      tick();
      bus.fpu_done   = 1'b1;
      bus.fpu_result = 32'h12345678;
      bus.fpu_status = 4'b0001;
      tick();
      bus.fpu_done = 1'b0;
      #1;
      chk_reset_outputs("mid.late");
      tick();
      chk("mid.rsp_valid_after", 32'(bus.rsp_valid), 32'h0);
      chk("mid.busy_after",      32'(busy),          32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles spent in WAIT for fpu_done before abort (legal range 2..255).
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  bit i = requester i has an operation pending.
REQ-005 req_ready  output  2  bit i = operation of requester i accepted this cycle.
REQ-006 req_op_a  input  64  operand A, lane i at [32i+31:32i], format sign[31], exp[30:25] (bias 31), mant[24:0].
REQ-007 req_op_b  input  64  operand B, same lane layout and format.
REQ-008 rsp_valid  output  2  bit i = one-cycle pulse, response for requester i on rsp_data/rsp_status.
REQ-009 rsp_data  output  32  result word.
REQ-010 rsp_status  output  4  status code: 0001 exact, 1111 inexact, 0011 overflow, 0111 underflow, 1001 timeout.
REQ-011 fpu_start  output  1  one-cycle pulse launching the shared FPU adder.
REQ-012 fpu_op_a / fpu_op_b  output  32 each  operands to FPU adder.
REQ-013 fpu_done  input  1  FPU adder result valid this cycle.
REQ-014 fpu_result  input  32  FPU adder result word.
REQ-015 fpu_status  input  4  FPU adder status code.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESPOND; exactly one transaction in flight at any time.
REQ-018 IDLE: if exactly one req_valid bit set, grant that requester; if both set, grant requester indicated by priority pointer; if none, stay IDLE.
REQ-019 req_ready[g] asserted combinationally only in IDLE for granted g; handshake = req_valid[g] & req_ready[g]; operands of lane g and g latched at that edge; next state ISSUE.
REQ-020 req_ready never asserted for both bits, never asserted outside IDLE.
REQ-021 ISSUE: fpu_start = 1 for exactly one cycle; next state WAIT; wait counter cleared to 0.
REQ-022 fpu_op_a/fpu_op_b driven from latched operands from ISSUE through end of WAIT; unchanged while not IDLE.
REQ-023 WAIT: counter increments each cycle; fpu_done = 1 captures fpu_result/fpu_status, next state RESPOND.
REQ-024 WAIT: counter reaching TIMEOUT-1 with fpu_done = 0 captures rsp_data = 0, rsp_status = 1001, next state RESPOND.
REQ-025 fpu_done and timeout in same cycle: fpu_done wins, FPU result/status delivered.
REQ-026 fpu_done outside WAIT ignored, no state or output change.
REQ-027 RESPOND: rsp_valid[g] = 1 for exactly one cycle with captured data/status; no backpressure; next state IDLE.
REQ-028 rsp_data/rsp_status hold last delivered value until next RESPOND.
REQ-029 Priority pointer updated in RESPOND to 1-g (round robin); pointer affects only simultaneous requests.
REQ-030 Latency: handshake at edge N -> fpu_start during cycle N+1 -> fpu_done at cycle N+1+k (k>=1) -> rsp_valid during cycle N+2+k.
REQ-031 New request accepted earliest in cycle after RESPOND (back-to-back throughput: one op per k+3 cycles).
REQ-032 Result word and status passed through unmodified; arbiter performs no arithmetic on operands.

Reset
REQ-033 reset low: state IDLE, pointer 0, counter 0, latched operands 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_status 0000, fpu_start 0, fpu_op_a/b 0, busy 0.
REQ-034 Reset mid-transaction abandons it: no rsp_valid issued for it; a late fpu_done after reset release is ignored per REQ-026.

Verification
REQ-035 Single request: req_valid=01, op_a=0x3E000000, op_b=0x3E000000, FPU model returns 0x40000000/0001 after k=3 -> req_ready=01 at cycle 0, fpu_start cycle 1, rsp_valid=01 cycle 5, rsp_data=0x40000000, rsp_status=0001.
REQ-036 Simultaneous requests after reset: req_valid=11 held -> requester 0 served first, then requester 1, then 0; rsp_valid alternates 01,10,01.
REQ-037 Timeout: TIMEOUT=8, fpu_done never asserted -> rsp_valid pulse after 8 WAIT cycles, rsp_data=0, rsp_status=1001, busy falls next cycle.
REQ-038 Done-vs-timeout collision: fpu_done on counter=TIMEOUT-1 with 0x7E000000/0011 -> rsp_status=0011, rsp_data=0x7E000000.
REQ-039 Reset asserted during WAIT, fpu_done pulsed 2 cycles after release -> no rsp_valid, all outputs at reset values, busy=0.
REQ-040 Spurious fpu_done in IDLE with req_valid=00 -> no rsp_valid, rsp_data/rsp_status unchanged.
